// File: rtl/gene_net_if.sv
`default_nettype none
// ============================================================================
// Module   : gene_net_if
// Brief    : Control/result bundle between the board front end and the
//            gene_net_sim engine. master = front end, slave = engine.
// Revision : 1.0  initial release
// ============================================================================
interface gene_net_if #(
    parameter int N  = 8,
    parameter int SW = 8
);
    logic             start;
    logic [N-1:0]     init_state;
    logic [N*N-1:0]   act_mask;
    logic [N*N-1:0]   rep_mask;
    logic [SW-1:0]    max_steps;
    logic             busy;
    logic             done;
    logic [N-1:0]     state;
    logic [SW-1:0]    steps;
    logic [1:0]       status;

    modport master (
        output start, init_state, act_mask, rep_mask, max_steps,
        input  busy, done, state, steps, status
    );

    modport slave (
        input  start, init_state, act_mask, rep_mask, max_steps,
        output busy, done, state, steps, status
    );
endinterface
`default_nettype wire

// File: rtl/gene_net_sim.sv
`default_nettype none
// ============================================================================
// Module   : gene_net_sim
// Brief    : Sequential Boolean gene-network engine. Iterates x <= f(x) from
//            a loaded initial state until a fixed point, a step limit or,
//            when GENE_NET_CYCLE2_EN is defined, a period-2 oscillation.
//            Node rules are runtime activator/repressor masks.
// Macro    : GENE_NET_CYCLE2_EN - enables period-2 cycle detection (status 11)
// Revision : 1.0  initial release
// ============================================================================
module gene_net_sim #(
    parameter int N  = 8,
    parameter int SW = 8
) (
    input  logic       clk,
    input  logic       rst,
    gene_net_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam logic [1:0] STAT_NONE  = 2'b00;
    localparam logic [1:0] STAT_FIXED = 2'b01;
    localparam logic [1:0] STAT_TIME  = 2'b10;
`ifdef GENE_NET_CYCLE2_EN
    localparam logic [1:0] STAT_CYC2  = 2'b11;
`endif

    logic [1:0]     fsm;
    logic [N-1:0]   cur_state;
    logic [SW-1:0]  step_cnt;
    logic [1:0]     run_status;
    logic [N*N-1:0] act_lat;
    logic [N*N-1:0] rep_lat;
    logic [SW-1:0]  max_lat;
    logic [N-1:0]   nxt;
`ifdef GENE_NET_CYCLE2_EN
    logic [N-1:0]   prev_state;
    logic           prev_valid;
`endif

    // Next-state rule: a node with no activators is constitutively on,
    // any active repressor forces it off.
    always_comb begin
        nxt = '0;
        for (int i = 0; i < N; i++) begin
            nxt[i] = ((act_lat[i*N +: N] == '0) || (|(cur_state & act_lat[i*N +: N])))
                     && !(|(cur_state & rep_lat[i*N +: N]));
        end
    end

    // Run controller: load on start, iterate with termination checks in
    // priority order, then a single FIN cycle before returning to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm        <= ST_IDLE;
            cur_state  <= '0;
            step_cnt   <= '0;
            run_status <= STAT_NONE;
            act_lat    <= '0;
            rep_lat    <= '0;
            max_lat    <= '0;
`ifdef GENE_NET_CYCLE2_EN
            prev_state <= '0;
            prev_valid <= 1'b0;
`endif
        end else begin
            case (fsm)
                ST_IDLE: begin
                    if (bus.start) begin
                        act_lat    <= bus.act_mask;
                        rep_lat    <= bus.rep_mask;
                        max_lat    <= bus.max_steps;
                        cur_state  <= bus.init_state;
                        step_cnt   <= '0;
                        run_status <= STAT_NONE;
`ifdef GENE_NET_CYCLE2_EN
                        prev_valid <= 1'b0;
`endif
                        fsm        <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (nxt == cur_state) begin
                        run_status <= STAT_FIXED;
                        fsm        <= ST_FIN;
                    end
`ifdef GENE_NET_CYCLE2_EN
                    else if (prev_valid && (nxt == prev_state) && (nxt != cur_state)) begin
                        run_status <= STAT_CYC2;
                        fsm        <= ST_FIN;
                    end
`endif
                    // Limit is tested before the increment so the counter never wraps.
                    else if (step_cnt == max_lat) begin
                        run_status <= STAT_TIME;
                        fsm        <= ST_FIN;
                    end else begin
                        cur_state  <= nxt;
                        step_cnt   <= step_cnt + 1'b1;
`ifdef GENE_NET_CYCLE2_EN
                        prev_state <= cur_state;
                        prev_valid <= 1'b1;
`endif
                    end
                end
                ST_FIN: begin
                    fsm <= ST_IDLE;
                end
                default: begin
                    fsm <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = (fsm == ST_RUN) || (fsm == ST_FIN);
    assign bus.done   = (fsm == ST_FIN);
    assign bus.state  = cur_state;
    assign bus.steps  = step_cnt;
    assign bus.status = run_status;

endmodule
`default_nettype wire
